// File: rtl/uart_core_fifo.sv
// Full-duplex UART with configurable frame format, RX/TX FIFOs on a valid/ready host side,
// parity/framing/overrun reporting and internal loopback.
module uart_core_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam int RW = DATA_BITS + 2;

    localparam logic          HAS_PAR   = (PARITY_MODE != 0);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);
    localparam logic [PW-1:0] FULL_XOR  = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4
    } rx_state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return ODD_PAR ? ~^d : ^d;
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem_r [FIFO_DEPTH];
    logic [PW-1:0]        tx_wr_r, tx_rd_r;
    logic                 tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
    logic [DATA_BITS-1:0] tx_head_s;

    assign tx_full_s  = ((tx_wr_r ^ tx_rd_r) == FULL_XOR);
    assign tx_empty_s = (tx_wr_r == tx_rd_r);
    assign tx_push_s  = tx_valid & ~tx_full_s;
    assign tx_head_s  = tx_mem_r[tx_rd_r[AW-1:0]];
    assign tx_ready   = ~tx_full_s;

    // TX FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_r <= '0;
            tx_rd_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_r[i] <= '0;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r[AW-1:0]] <= tx_data;
                tx_wr_r <= tx_wr_r + {{AW{1'b0}}, 1'b1};
            end
            if (tx_pop_s) begin
                tx_rd_r <= tx_rd_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t            tx_state_r, tx_state_s;
    logic [CW-1:0]        tx_cnt_r, tx_cnt_s;
    logic [IW-1:0]        tx_idx_r, tx_idx_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                 tx_par_r, tx_par_s;
    logic                 tx_r, tx_s, tx_busy_r, tx_busy_s;

    // TX state, shifter and registered line/busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_idx_r   <= '0;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_idx_r   <= tx_idx_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_r       <= tx_s;
            tx_busy_r  <= tx_busy_s;
        end
    end

    // TX next state; tx_s is the line value for the upcoming cycle
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + CNT_ONE;
        tx_idx_s   = tx_idx_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        tx_s       = tx_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = '0;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_head_s;
                    tx_par_s   = parity_bit(tx_head_s);
                    tx_state_s = TX_START;
                    tx_s       = 1'b0;
                end else begin
                    tx_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_idx_s   = '0;
                    tx_state_s = TX_DATA;
                    tx_s       = tx_shift_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_idx_r == IDX_LAST) begin
                        tx_state_s = HAS_PAR ? TX_PARITY : TX_STOP;
                        tx_s       = HAS_PAR ? tx_par_r : 1'b1;
                    end else begin
                        tx_idx_s   = tx_idx_r + IDX_ONE;
                        tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                        tx_s       = tx_shift_r[1];
                    end
                end else begin
                    tx_s = tx_shift_r[0];
                end
            end
            TX_PARITY: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_state_s = TX_STOP;
                    tx_s       = 1'b1;
                end else begin
                    tx_s = tx_par_r;
                end
            end
            TX_STOP: begin
                tx_s = 1'b1;
                if (tx_cnt_r == STOP_LAST) begin
                    tx_cnt_s   = '0;
                    tx_state_s = TX_IDLE;
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = '0;
                tx_s       = 1'b1;
            end
        endcase
        tx_busy_s = (tx_state_s != TX_IDLE);
    end

    assign tx      = tx_r;
    assign tx_busy = tx_busy_r;

    // ---------------- RX deserialiser ----------------
    logic                 rx_meta_r, rx_sync_r, line_prev_r;
    logic                 line_s, fall_s;
    rx_state_t            rx_state_r, rx_state_s;
    logic [CW-1:0]        rx_cnt_r, rx_cnt_s;
    logic [IW-1:0]        rx_idx_r, rx_idx_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic                 rx_par_r, rx_par_s;
    logic                 stop_sample_s;

    // Loopback taps the registered tx line, which is already in this clock domain
    assign line_s = loopback ? tx_r : rx_sync_r;
    assign fall_s = line_prev_r & ~line_s;

    // Synchroniser, edge history and RX FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            line_prev_r <= 1'b1;
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= '0;
            rx_idx_r    <= '0;
            rx_shift_r  <= '0;
            rx_par_r    <= 1'b0;
        end else begin
            rx_meta_r   <= rx;
            rx_sync_r   <= rx_meta_r;
            line_prev_r <= line_s;
            rx_state_r  <= rx_state_s;
            rx_cnt_r    <= rx_cnt_s;
            rx_idx_r    <= rx_idx_s;
            rx_shift_r  <= rx_shift_s;
            rx_par_r    <= rx_par_s;
        end
    end

    // RX next state; a held-low line never produces a new falling edge, so breaks cannot retrigger
    always_comb begin
        rx_state_s    = rx_state_r;
        rx_cnt_s      = rx_cnt_r + CNT_ONE;
        rx_idx_s      = rx_idx_r;
        rx_shift_s    = rx_shift_r;
        rx_par_s      = rx_par_r;
        stop_sample_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = '0;
                if (fall_s) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s   = '0;
                    rx_idx_s   = '0;
                    rx_state_s = line_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {line_s, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_idx_r == IDX_LAST) begin
                        rx_state_s = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_s = rx_idx_r + IDX_ONE;
                    end
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_par_s   = line_s;
                    rx_state_s = RX_STOP;
                end else begin
                    rx_state_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s      = '0;
                    stop_sample_s = 1'b1;
                    rx_state_s    = RX_IDLE;
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [RW-1:0] rx_mem_r [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_r, rx_rd_r, rx_wr_next_s, rx_rd_next_s;
    logic [RW-1:0] rx_entry_s, rx_head_s, rx_head_r;
    logic          rx_full_s, rx_push_s, rx_pop_s, rx_valid_r, rx_ovr_r;

    assign rx_full_s    = ((rx_wr_r ^ rx_rd_r) == FULL_XOR);
    assign rx_entry_s   = {~line_s, HAS_PAR & (rx_par_r != parity_bit(rx_shift_r)), rx_shift_r};
    assign rx_push_s    = stop_sample_s & ~rx_full_s;
    assign rx_pop_s     = rx_valid_r & rx_ready;
    assign rx_wr_next_s = rx_wr_r + {{AW{1'b0}}, rx_push_s};
    assign rx_rd_next_s = rx_rd_r + {{AW{1'b0}}, rx_pop_s};
    // A push into the slot that becomes the head must bypass the memory
    assign rx_head_s    = (rx_push_s && (rx_wr_r[AW-1:0] == rx_rd_next_s[AW-1:0])) ?
                          rx_entry_s : rx_mem_r[rx_rd_next_s[AW-1:0]];

    // RX FIFO storage, pointers, registered head and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_r    <= '0;
            rx_rd_r    <= '0;
            rx_head_r  <= '0;
            rx_valid_r <= 1'b0;
            rx_ovr_r   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_r[i] <= '0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_r[AW-1:0]] <= rx_entry_s;
            end
            rx_wr_r    <= rx_wr_next_s;
            rx_rd_r    <= rx_rd_next_s;
            rx_head_r  <= rx_head_s;
            rx_valid_r <= (rx_wr_next_s != rx_rd_next_s);
            rx_ovr_r   <= stop_sample_s & rx_full_s;
        end
    end

    assign rx_data       = rx_head_r[DATA_BITS-1:0];
    assign rx_parity_err = rx_head_r[DATA_BITS];
    assign rx_frame_err  = rx_head_r[DATA_BITS+1];
    assign rx_valid      = rx_valid_r;
    assign rx_overrun    = rx_ovr_r;

endmodule

// File: tb/tb_uart_core_fifo.sv
// Directed bench for uart_core_fifo: default-format instance (a) plus an odd-parity instance (b).
module tb_uart_core_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       rx_a, tx_a, loopback_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
    logic       perr_a, ferr_a, ovr_a, tx_busy_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       rx_b, tx_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
    logic       perr_b, ferr_b, ovr_b, tx_busy_b;
    logic [7:0] tx_data_b, rx_data_b;

    uart_core_fifo dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a), .loopback(loopback_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .tx_busy(tx_busy_a)
    );

    uart_core_fifo #(.PARITY_MODE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .tx(tx_b), .loopback(1'b0),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .tx_busy(tx_busy_b)
    );

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ovr_frame = -1;
    int frame_idx = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[5];

    always @(negedge clk) begin
        if (ovr_a === 1'b1) begin
            ovr_cnt   <= ovr_cnt + 1;
            ovr_frame <= frame_idx;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 1) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        set_rx(which, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            set_rx(which, par);
            repeat (16) @(negedge clk);
        end
        set_rx(which, stop);
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_rx(input int which, input string name);
        int n = 0;
        while (((which == 1) ? rx_valid_b : rx_valid_a) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, {31'd0, (which == 1) ? rx_valid_b : rx_valid_a}, 32'd1);
    endtask

    task automatic pop(input int which);
        if (which == 1) rx_ready_b = 1'b1;
        else rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wave;
        logic [7:0] lb [3];
        logic [7:0] b;
        int busy_cnt;

        vecs[0] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'hA7, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
        wave  = {1'b1, 8'hA5, 1'b0};
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;

        rst_n = 1'b0;
        rx_a = 1'b1; loopback_a = 1'b0; tx_data_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
        rx_b = 1'b1; tx_data_b = 8'h00; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx_a}, 32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy_a}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready_a}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid_a}, 32'd0);
        chk("rst_rx_overrun", {31'd0, ovr_a}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data_a}, 32'd0);
        chk("rst_perr", {31'd0, perr_a}, 32'd0);
        chk("rst_ferr", {31'd0, ferr_a}, 32'd0);
        chk("rst_b_rx_valid", {31'd0, rx_valid_b}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // TX waveform for 0xA5
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        chk("tx_high_after_accept", {31'd0, tx_a}, 32'd1);
        @(negedge clk);
        chk("tx_start_latency", {31'd0, tx_a}, 32'd0);
        chk("tx_busy_rise", {31'd0, tx_busy_a}, 32'd1);
        busy_cnt = 0;
        for (int j = 0; j < 170; j++) begin
            if (tx_busy_a) busy_cnt++;
            if (j < 160 && (j % 16) == 8)
                chk($sformatf("tx_bit%0d", j / 16), {31'd0, tx_a}, {31'd0, wave[j / 16]});
            @(negedge clk);
        end
        chk("tx_busy_cycles", busy_cnt, 32'd160);

        // Loopback, three back-to-back bytes
        loopback_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tx_data_a = lb[k]; tx_valid_a = 1'b1;
            @(negedge clk);
            chk($sformatf("lb_tx_ready%0d", k), {31'd0, tx_ready_a}, 32'd1);
        end
        tx_valid_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_rx(0, $sformatf("lb%0d", k));
            chk($sformatf("lb_data%0d", k), {24'd0, rx_data_a}, {24'd0, lb[k]});
            chk($sformatf("lb_perr%0d", k), {31'd0, perr_a}, 32'd0);
            chk($sformatf("lb_ferr%0d", k), {31'd0, ferr_a}, 32'd0);
            pop(0);
        end
        repeat (40) @(negedge clk);
        loopback_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("lb_rx_empty", {31'd0, rx_valid_a}, 32'd0);

        // Odd-parity instance, table-driven
        for (int i = 0; i < 5; i++) begin
            send_frame(1, vecs[i].data, 1'b1, vecs[i].par, vecs[i].stop);
            set_rx(1, 1'b1);
            wait_rx(1, $sformatf("par%0d", i));
            chk($sformatf("par_data%0d", i), {24'd0, rx_data_b}, {24'd0, vecs[i].exp_data});
            chk($sformatf("par_perr%0d", i), {31'd0, perr_b}, {31'd0, vecs[i].exp_perr});
            chk($sformatf("par_ferr%0d", i), {31'd0, ferr_b}, {31'd0, vecs[i].exp_ferr});
            pop(1);
            repeat (32) @(negedge clk);
        end

        // Framing error followed by a held break
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        wait_rx(0, "ferr");
        chk("ferr_data", {24'd0, rx_data_a}, 32'h81);
        chk("ferr_flag", {31'd0, ferr_a}, 32'd1);
        chk("ferr_perr", {31'd0, perr_a}, 32'd0);
        pop(0);
        repeat (48) @(negedge clk);
        chk("break_no_push", {31'd0, rx_valid_a}, 32'd0);
        set_rx(0, 1'b1);
        repeat (32) @(negedge clk);
        chk("break_release_no_push", {31'd0, rx_valid_a}, 32'd0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        wait_rx(0, "after_break");
        chk("after_break_data", {24'd0, rx_data_a}, 32'h42);
        chk("after_break_ferr", {31'd0, ferr_a}, 32'd0);
        pop(0);
        repeat (8) @(negedge clk);

        // Overrun: five frames into a depth-4 FIFO with no pops
        for (int f = 0; f < 5; f++) begin
            frame_idx = f;
            b = 8'h11 + 8'(f);
            send_frame(0, b, 1'b0, 1'b0, 1'b1);
            repeat (4) @(negedge clk);
        end
        chk("ovr_count", ovr_cnt, 32'd1);
        chk("ovr_on_fifth", ovr_frame, 32'd4);
        for (int f = 0; f < 4; f++) begin
            wait_rx(0, $sformatf("ovr_pop%0d", f));
            b = 8'h11 + 8'(f);
            chk($sformatf("ovr_data%0d", f), {24'd0, rx_data_a}, {24'd0, b});
            pop(0);
        end
        chk("ovr_drained", {31'd0, rx_valid_a}, 32'd0);

        // Short glitch on idle rx, then a good frame
        set_rx(0, 1'b0);
        repeat (5) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (40) @(negedge clk);
        chk("glitch_no_push", {31'd0, rx_valid_a}, 32'd0);
        send_frame(0, 8'h6B, 1'b0, 1'b0, 1'b1);
        wait_rx(0, "after_glitch");
        chk("after_glitch_data", {24'd0, rx_data_a}, 32'h6B);
        pop(0);

        // Reset in the middle of a TX frame with more data queued
        tx_data_a = 8'h3C; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'hC3;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("midtx_busy", {31'd0, tx_busy_a}, 32'd1);
        chk("midtx_tx_low", {31'd0, tx_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx_a}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy_a}, 32'd0);
        chk("midrst_tx_ready", {31'd0, tx_ready_a}, 32'd1);
        chk("midrst_rx_valid", {31'd0, rx_valid_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("postrst_tx_idle", {31'd0, tx_a}, 32'd1);
        chk("postrst_fifo_empty", {31'd0, tx_busy_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core_fifo.md
Name: uart_core_fifo

Overview:
- Parametrised full-duplex UART with configurable frame format and independent RX/TX FIFOs.
- Host side uses valid/ready handshakes; line side is the serial `rx`/`tx` pair.
- Replaces the fixed 8-bit receiver/transmitter pair in the UART top.
- Adds parity checking, framing and overrun detection, configurable stop bits, internal loopback and buffering.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; minimum 4.
- DATA_BITS, 8: payload bits per frame, 5..8, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries per FIFO; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input; asynchronous to clk, idle high.
- tx  out  1  serial output, idle high.
- loopback  in  1  1 = the RX deserialiser takes the internal tx line instead of rx; the external tx pin still drives.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  host offers tx_data.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_BITS  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host consumes the RX head.
- rx_parity_err  out  1  parity error flag of the head entry; qualified by rx_valid.
- rx_frame_err  out  1  stop-bit error flag of the head entry; qualified by rx_valid.
- rx_overrun  out  1  one-cycle pulse when a received frame is dropped because the RX FIFO is full.
- tx_busy  out  1  TX shifter is not idle.

Behaviour:
- Reset (asynchronous, immediate): tx = 1, tx_busy = 0, tx_ready = 1, rx_valid = 0, rx_overrun = 0, rx_parity_err = 0, rx_frame_err = 0, rx_data = 0; both FIFOs empty; both FSMs IDLE.
  - Reset mid-frame aborts the frame; no partial byte is pushed.
- Handshakes:
  - TX push when tx_valid & tx_ready. RX pop when rx_valid & rx_ready.
  - Simultaneous push and pop on the same FIFO are both legal, and the count is unchanged.
  - tx_ready deasserts at full, with no same-cycle bypass on pop.
  - rx_data and its flags are the registered head entry; they update the cycle after a pop.
- FIFOs: pointer width $clog2(FIFO_DEPTH)+1, wrapping naturally.
  - RX entry = {frame_err, parity_err, data}.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - Each state lasts exactly CLKS_PER_BIT cycles, timed by a per-FSM bit counter.
  - IDLE with TX FIFO non-empty: pop the entry, drive tx = 0 on the next cycle, tx_busy = 1.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: present only if PARITY_MODE != 0. Even mode sends ^data; odd mode sends ~^data.
  - STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - After STOP: return to IDLE, with tx_busy = 0 for at least one cycle before the next START. Back-to-back frames therefore have a 1-cycle minimum gap.
- RX path: 2-flop synchroniser on rx, then the loopback mux.
  - IDLE: a falling edge (1 → 0) starts the bit counter.
  - START: sampled at CLKS_PER_BIT/2. If it reads 1, treat as a glitch and return to IDLE with no push.
  - DATA and PARITY bits: each sampled CLKS_PER_BIT after the previous sample, at mid-bit.
  - parity_err = received parity != computed parity; always 0 when PARITY_MODE = 0.
  - STOP: only the first stop bit is checked, with frame_err = (sample == 0).
  - Push decision, made on the cycle of the first stop-bit sample:
    - If the RX FIFO is not full, push the entry.
    - Else drop the frame and pulse rx_overrun for 1 cycle; FIFO contents are unchanged.
  - Return to IDLE at the mid-point of the first stop bit, so a following start edge is caught.
  - On frame_err, the FSM still re-arms only after the line reads 1, which prevents a break from retriggering.
- Latency:
  - tx_valid accepted in cycle N → tx falls at cycle N+2 when idle.
  - The push occurs at first-stop mid-sample + 1 cycle; rx_valid rises in that same cycle.
- Loopback toggled mid-frame: the behaviour is the same as a line glitch, and the next frame must be received correctly.

Test Plan:
- Defaults, push 0xA5 → tx waveform 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles; tx_busy high for 160 cycles.
- loopback = 1, push 0x00, 0xFF, 0x5A back-to-back → RX pops the same three bytes in order with both error flags 0; tx_ready stays 1 (depth 4).
- PARITY_MODE = 2, drive rx frame 0x3C with a wrong parity bit → rx_data = 0x3C, rx_parity_err = 1; the next correct frame reads parity_err = 0.
- Drive rx frame 0x81 with stop bit = 0 → rx_frame_err = 1, rx_data = 0x81; then hold rx low 3 bit-times → no further push until rx returns high.
- With rx_ready = 0, send 5 frames at depth 4 → rx_overrun pulses once, on the 5th frame; the pops return frames 1..4.
- 5-cycle low glitch on idle rx → no push; also assert rst_n low mid-TX-frame → tx = 1 immediately, FIFOs empty, tx_ready = 1.
